mult_err_monitor: RTL and testbench

MULT_ERR_MONITOR -- requirements
Module: mult_err_monitor

---
 rtl/mult_err_monitor.sv | 162 ++++++++++++++++
 tb/tb_mult_err_monitor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_err_monitor.sv
// Error-statistics monitor for an exact or approximate W x W multiplier.
// Accepts n_samples (a, b, p_dut) triples and accumulates error-distance statistics.
module mult_err_monitor #(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned SUM_W = 2 * W + CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   n_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic [2*W-1:0]     p_dut,
    output logic               busy,
    output logic               done,
    output logic [CNT_W:0]     err_count,
    output logic [SUM_W-1:0]   sum_ed,
    output logic [2*W-1:0]     max_ed,
    output logic [SUM_W:0]     bias
);

    localparam int unsigned PW     = 2 * W;
    localparam int unsigned BiasExt = SUM_W - PW;
    localparam logic [CNT_W:0] CntOne = (CNT_W + 1)'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [CNT_W:0]   target_q, cnt_q;
    logic             accept, launch;

    logic             s1_valid_q;
    logic [W-1:0]     s1_a_q, s1_b_q;
    logic [PW-1:0]    s1_p_q;

    logic             s2_valid_q;
    logic [PW:0]      s2_diff_q;
    logic [PW-1:0]    s2_ed_q;

    logic [PW-1:0]    exact_c;
    logic [PW:0]      diff_c, neg_c;
    logic [PW-1:0]    ed_c;

    logic [CNT_W:0]   err_q;
    logic [SUM_W-1:0] sum_q;
    logic [PW-1:0]    max_q;
    logic [SUM_W:0]   bias_q;

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        launch   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    launch  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy     = 1'b1;
                in_ready = cnt_q < target_q;
                if (in_valid && (cnt_q < target_q) && ((cnt_q + CntOne) == target_q)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                busy = 1'b1;
                // Last sample is in stage 2 and nothing follows it: accumulate and finish.
                if (s2_valid_q && !s1_valid_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done = 1'b1;
                if (start) begin
                    launch  = 1'b1;
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign exact_c = PW'(s1_a_q) * PW'(s1_b_q);
    assign diff_c  = {1'b0, s1_p_q} - {1'b0, exact_c};
    assign neg_c   = '0 - diff_c;
    assign ed_c    = diff_c[PW] ? neg_c[PW-1:0] : diff_c[PW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_p_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_diff_q  <= '0;
            s2_ed_q    <= '0;
            target_q   <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            sum_q      <= '0;
            max_q      <= '0;
            bias_q     <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_a_q <= a;
                s1_b_q <= b;
                s1_p_q <= p_dut;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_diff_q <= diff_c;
                s2_ed_q   <= ed_c;
            end
            if (launch) begin
                // A zero count selects the full 2^CNT_W-sample run.
                target_q <= (n_samples == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, n_samples};
                cnt_q    <= '0;
                err_q    <= '0;
                sum_q    <= '0;
                max_q    <= '0;
                bias_q   <= '0;
            end else begin
                if (accept) begin
                    cnt_q <= cnt_q + CntOne;
                end
                if (s2_valid_q) begin
                    err_q  <= err_q + (CNT_W + 1)'(s2_ed_q != '0);
                    sum_q  <= sum_q + SUM_W'(s2_ed_q);
                    bias_q <= bias_q + {{BiasExt{s2_diff_q[PW]}}, s2_diff_q};
                    if (s2_ed_q > max_q) begin
                        max_q <= s2_ed_q;
                    end
                end
            end
        end
    end

    assign err_count = err_q;
    assign sum_ed    = sum_q;
    assign max_ed    = max_q;
    assign bias      = bias_q;

endmodule

// File: tb/tb_mult_err_monitor.sv
// Scoreboard bench for mult_err_monitor: expected statistics are queued per run and
// popped by a monitor on each rising edge of done.
module tb_mult_err_monitor;

    localparam int W     = 4;
    localparam int CNT_W = 8;
    localparam int SUM_W = 2 * W + CNT_W;

    typedef struct {
        longint err;
        longint sum;
        longint mx;
        longint bs;
    } stats_t;

    logic               clk = 1'b0;
    logic               rst, start, in_valid, in_ready, busy, done;
    logic [CNT_W-1:0]   n_samples;
    logic [W-1:0]       a, b;
    logic [2*W-1:0]     p_dut;
    logic [CNT_W:0]     err_count;
    logic [SUM_W-1:0]   sum_ed;
    logic [2*W-1:0]     max_ed;
    logic [SUM_W:0]     bias;

    int total = 0;
    int bad   = 0;
    int acc_seen = 0;
    int q_a[$], q_b[$], q_p[$];
    stats_t exp_q[$];
    stats_t mon_e;
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    mult_err_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .p_dut(p_dut),
        .busy(busy), .done(done), .err_count(err_count), .sum_ed(sum_ed),
        .max_ed(max_ed), .bias(bias)
    );

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: statistics straight from the definition of error distance.
    function automatic stats_t model();
        stats_t s;
        s = '{0, 0, 0, 0};
        foreach (q_a[i]) begin
            longint d, e;
            d = longint'(q_p[i]) - longint'(q_a[i] * q_b[i]);
            e = (d < 0) ? -d : d;
            s.err += (e != 0) ? 1 : 0;
            s.sum += e;
            s.bs  += d;
            if (e > s.mx) s.mx = e;
        end
        return s;
    endfunction

    always @(posedge clk) if (in_valid && in_ready) acc_seen++;

    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("err_count", longint'(err_count), mon_e.err);
                check("sum_ed", longint'(sum_ed), mon_e.sum);
                check("max_ed", longint'(max_ed), mon_e.mx);
                check("bias", longint'($signed(bias)), mon_e.bs);
            end
        end
        done_prev <= done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        n_samples = CNT_W'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic check_stats_zero(input string tag);
        check({tag, "_err"}, longint'(err_count), 0);
        check({tag, "_sum"}, longint'(sum_ed), 0);
        check({tag, "_max"}, longint'(max_ed), 0);
        check({tag, "_bias"}, longint'($signed(bias)), 0);
    endtask

    task automatic gen(input int n);
        q_a = {}; q_b = {}; q_p = {};
        for (int i = 0; i < n; i++) begin
            int x, y;
            x = $urandom_range(0, 15);
            y = $urandom_range(0, 15);
            q_a.push_back(x);
            q_b.push_back(y);
            q_p.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(0, 255) : x * y);
        end
    endtask

    // Present samples [from, to) until each is accepted; bubbles toggles in_valid.
    task automatic feed(input bit bubbles, input int from, input int to);
        int idx, guard;
        bit phase;
        idx = from; guard = 0; phase = 1'b1;
        while (idx < to && guard < 2000) begin
            a        = W'(q_a[idx]);
            b        = W'(q_b[idx]);
            p_dut    = (2*W)'(q_p[idx]);
            in_valid = bubbles ? phase : 1'b1;
            phase    = ~phase;
            if (in_valid && in_ready) idx++;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (idx < to) check("feed_timeout", idx, to);
    endtask

    task automatic hold_and_wait(input int n_exp);
        int guard;
        // Extra valid data after the run must be ignored.
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom); p_dut = (2*W)'($urandom);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        guard = 0;
        while (!done && guard < 40) begin
            tick();
            guard++;
        end
        check("done_reached", longint'(done), 1);
        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        check("accept_count", acc_seen, n_exp);
    endtask

    task automatic run(input int n, input bit bubbles);
        exp_q.push_back(model());
        acc_seen = 0;
        do_start(n);
        check("start_busy", longint'(busy), 1);
        check_stats_zero("start_clear");
        feed(bubbles, 0, q_a.size());
        hold_and_wait(q_a.size());
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; in_valid = 1'b0; n_samples = '0;
        a = '0; b = '0; p_dut = '0;
        tick();
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_ready", longint'(in_ready), 0);
        check_stats_zero("rst");

        // Single-sample latency: 7*9=63, p=60 -> diff -3.
        q_a = {7}; q_b = {9}; q_p = {60};
        exp_q.push_back(model());
        do_start(1);
        check("t_ready_run", longint'(in_ready), 1);
        a = 4'd7; b = 4'd9; p_dut = 8'd60; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t_ready_after", longint'(in_ready), 0);
        check("t_busy_e", longint'(busy), 1);
        check("t_done_e", longint'(done), 0);
        tick();
        check("t_done_e1", longint'(done), 0);
        check("t_sum_e1", longint'(sum_ed), 0);
        tick();
        check("t_done_e2", longint'(done), 1);
        check("t_busy_e2", longint'(busy), 0);
        check("t_sum_e2", longint'(sum_ed), 3);
        tick();

        // Exhaustive exact products over a 2^CNT_W-sample run.
        q_a = {}; q_b = {}; q_p = {};
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
                q_a.push_back(x); q_b.push_back(y); q_p.push_back(x * y);
            end
        run(0, 1'b0);

        q_a = {15, 3, 2}; q_b = {15, 5, 2}; q_p = {225, 14, 6};
        run(3, 1'b0);

        gen(4);
        run(4, 1'b1);
        run(4, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 40);
            gen(n);
            run(n, 1'(r % 2));
        end

        // start during RUN must not restart or retarget the run.
        gen(5);
        exp_q.push_back(model());
        acc_seen = 0;
        do_start(5);
        feed(1'b0, 0, 2);
        n_samples = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("run_start_busy", longint'(busy), 1);
        feed(1'b0, 2, 5);
        hold_and_wait(5);

        // Reset in the middle of a 20-sample run.
        gen(20);
        acc_seen = 0;
        do_start(20);
        feed(1'b0, 0, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_ready", longint'(in_ready), 0);
        check("mid_rst_done", longint'(done), 0);
        check_stats_zero("mid_rst");
        tick();
        tick();
        check_stats_zero("post_rst");
        gen(2);
        run(2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
